// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and slot placement helper.
package cnn_pkg;

    localparam int unsigned CONV_ROW_W      = 448;
    localparam int unsigned DEF_NCH         = 2;
    localparam int unsigned DEF_PERIOD      = 26;
    localparam int unsigned DEF_FIRST_SLOT  = 2;
    localparam int unsigned DEF_SLOT_STRIDE = 12;

    // Slot at which channel k captures its row.
    function automatic int unsigned slot_of(
        input int unsigned k,
        input int unsigned first_slot  = DEF_FIRST_SLOT,
        input int unsigned slot_stride = DEF_SLOT_STRIDE
    );
        return first_slot + k * slot_stride;
    endfunction

endpackage

// File: rtl/conv_slot_counter.sv
// Beat slot counter for the conv row demux.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid        a beat is present; advances the counter
//   in_frame_start  resync; the current beat (if any) is slot 0
//   beat_slot_c     slot of the beat presented this cycle (resync applied)
//   advance_c       strobe: this cycle's beat consumes a slot
module conv_slot_counter
    import cnn_pkg::*;
#(
    parameter int unsigned PERIOD = DEF_PERIOD,
    localparam int unsigned SLOT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_frame_start,
    output logic [SLOT_W-1:0] beat_slot_c,
    output logic              advance_c
);

    logic [SLOT_W-1:0] slot_q;
    logic [SLOT_W-1:0] slot_nxt;

    // Resync overrides the stored count for the beat in flight.
    always_comb begin
        beat_slot_c = in_frame_start ? '0 : slot_q;
        advance_c   = in_valid;
    end

    // Next slot: resync alone parks at 0; any valid beat steps past its slot.
    always_comb begin
        slot_nxt = slot_q;
        if (in_frame_start) begin
            slot_nxt = '0;
        end
        if (in_valid) begin
            slot_nxt = (beat_slot_c == SLOT_W'(PERIOD - 1)) ? '0
                                                             : beat_slot_c + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_nxt;
        end
    end

endmodule

// File: rtl/conv_row_demux.sv
// Time-slot demultiplexer: captures conv row beats at per-channel slot
// offsets and holds each row for its pooling consumer under valid/ack.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_data         conv row beat
//   in_valid        beat valid; only valid beats advance the slot counter
//   in_frame_start  resync slot counter to 0
//   out_data        channel k at [k*DATA_W +: DATA_W]
//   out_valid       channel k holds an unconsumed row
//   out_ack         channel k consumer takes the row
//   bundle_valid    one-cycle pulse after the last channel captures
//   overrun         sticky: channel k overwritten while unconsumed
module conv_row_demux
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W      = CONV_ROW_W,
    parameter int unsigned NCH         = DEF_NCH,
    parameter int unsigned PERIOD      = DEF_PERIOD,
    parameter int unsigned FIRST_SLOT  = DEF_FIRST_SLOT,
    parameter int unsigned SLOT_STRIDE = DEF_SLOT_STRIDE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    input  logic                  in_frame_start,
    output logic [NCH*DATA_W-1:0] out_data,
    output logic [NCH-1:0]        out_valid,
    input  logic [NCH-1:0]        out_ack,
    output logic                  bundle_valid,
    output logic [NCH-1:0]        overrun
);

    localparam int unsigned SLOT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    // Every channel's slot must fit inside one period.
    if (NCH < 1) begin : g_bad_nch
        $error("conv_row_demux: NCH must be at least 1");
    end else if (slot_of(NCH - 1, FIRST_SLOT, SLOT_STRIDE) >= PERIOD) begin : g_bad_slots
        $error("conv_row_demux: last channel slot exceeds PERIOD-1");
    end

    logic [SLOT_W-1:0] beat_slot_c;
    logic              advance_c;
    logic [NCH-1:0]    cap_c;

    conv_slot_counter #(
        .PERIOD (PERIOD)
    ) u_slot_counter (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_frame_start (in_frame_start),
        .beat_slot_c    (beat_slot_c),
        .advance_c      (advance_c)
    );

    // Per-channel holding register, handshake and overrun flag.
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [DATA_W-1:0] data_q;
        logic              valid_q;
        logic              ovr_q;

        assign cap_c[k] = advance_c &&
                          (beat_slot_c == SLOT_W'(slot_of(k, FIRST_SLOT, SLOT_STRIDE)));

        // Capture beats a same-cycle ack: the fresh row stays pending.
        always_ff @(posedge clk) begin
            if (rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
                ovr_q   <= 1'b0;
            end else if (cap_c[k]) begin
                data_q  <= in_data;
                valid_q <= 1'b1;
                if (valid_q && !out_ack[k]) begin
                    ovr_q <= 1'b1;
                end
            end else if (out_ack[k]) begin
                valid_q <= 1'b0;
            end
        end

        assign out_data[k*DATA_W +: DATA_W] = data_q;
        assign out_valid[k]                 = valid_q;
        assign overrun[k]                   = ovr_q;
    end

    // Bundle complete once the last channel has captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            bundle_valid <= 1'b0;
        end else begin
            bundle_valid <= cap_c[NCH-1];
        end
    end

endmodule

// File: tb/tb_conv_row_demux.sv
// Self-checking bench for conv_row_demux (default parameters).
module tb_conv_row_demux;

    localparam int unsigned DW  = 448;
    localparam int unsigned NCH = 2;
    localparam int unsigned PER = 26;
    localparam int unsigned FS  = 2;
    localparam int unsigned ST  = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_frame_start;
    logic [NCH*DW-1:0] out_data;
    logic [NCH-1:0]    out_valid;
    logic [NCH-1:0]    out_ack;
    logic              bundle_valid;
    logic [NCH-1:0]    overrun;

    conv_row_demux dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_frame_start (in_frame_start),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ack        (out_ack),
        .bundle_valid   (bundle_valid),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pulse_cnt = 0;

    // Reference model: beats since last resync, position = count mod PERIOD.
    logic [DW-1:0]  m_data [NCH];
    logic [NCH-1:0] m_valid;
    logic [NCH-1:0] m_ovr;
    logic           m_bundle;
    int             m_cnt;

    typedef struct {
        logic [7:0]     d;
        logic [NCH-1:0] ev;
        logic [NCH-1:0] eo;
        logic           eb;
        logic [7:0]     ed0;
        logic [7:0]     ed1;
    } vec_t;

    vec_t tbl [52];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand_row();
        logic [DW-1:0] r = '0;
        for (int i = 0; i < 14; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_update(input logic r, input logic v, input logic f,
                                input logic [DW-1:0] d, input logic [NCH-1:0] a);
        logic [NCH-1:0] got;
        int pos;
        got = '0;
        if (r) begin
            for (int k = 0; k < NCH; k++) m_data[k] = '0;
            m_valid = '0;
            m_ovr = '0;
            m_bundle = 1'b0;
            m_cnt = 0;
        end else begin
            m_bundle = 1'b0;
            if (f) m_cnt = 0;
            if (v) begin
                pos = m_cnt % PER;
                for (int k = 0; k < NCH; k++) begin
                    if (pos == int'(FS + k * ST)) begin
                        if (m_valid[k] && !a[k]) m_ovr[k] = 1'b1;
                        m_data[k]  = d;
                        m_valid[k] = 1'b1;
                        got[k]     = 1'b1;
                        if (k == NCH - 1) m_bundle = 1'b1;
                    end
                end
                m_cnt++;
            end
            for (int k = 0; k < NCH; k++) begin
                if (!got[k] && a[k]) m_valid[k] = 1'b0;
            end
        end
    endtask

    // One clock: drive, update model, sample #1 after the edge, compare.
    task automatic step(input logic r, input logic v, input logic f,
                        input logic [DW-1:0] d, input logic [NCH-1:0] a);
        rst = r;
        in_valid = v;
        in_frame_start = f;
        in_data = d;
        out_ack = a;
        @(posedge clk);
        model_update(r, v, f, d, a);
        #1;
        if (bundle_valid === 1'b1) pulse_cnt++;
        chk("m_valid", DW'(out_valid), DW'(m_valid));
        chk("m_overrun", DW'(overrun), DW'(m_ovr));
        chk("m_bundle", DW'(bundle_valid), DW'(m_bundle));
        for (int k = 0; k < NCH; k++)
            chk($sformatf("m_data%0d", k), out_data[k*DW +: DW], m_data[k]);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_frame_start = 1'b0;
        in_data = '0;
        out_ack = '0;
        for (int k = 0; k < NCH; k++) m_data[k] = '0;
        m_valid = '0;
        m_ovr = '0;
        m_bundle = 1'b0;
        m_cnt = 0;

        // Expected values for two back-to-back periods, no ack.
        for (int i = 0; i < 52; i++) begin
            tbl[i].d   = 8'(i);
            tbl[i].ev  = {1'(i >= 14), 1'(i >= 2)};
            tbl[i].eo  = {1'(i >= 40), 1'(i >= 28)};
            tbl[i].eb  = (i == 14) || (i == 40);
            tbl[i].ed0 = (i >= 28) ? 8'd28 : ((i >= 2) ? 8'd2 : 8'd0);
            tbl[i].ed1 = (i >= 40) ? 8'd40 : ((i >= 14) ? 8'd14 : 8'd0);
        end

        // Reset state.
        do_reset();
        chk("rst_valid", DW'(out_valid), DW'(0));
        chk("rst_overrun", DW'(overrun), DW'(0));
        chk("rst_bundle", DW'(bundle_valid), DW'(0));
        chk("rst_data0", out_data[0 +: DW], DW'(0));
        chk("rst_data1", out_data[DW +: DW], DW'(0));

        // Table: two periods of consecutive beats.
        for (int i = 0; i < 52; i++) begin
            step(1'b0, 1'b1, 1'b0, DW'(tbl[i].d), '0);
            chk($sformatf("tbl%0d_valid", i), DW'(out_valid), DW'(tbl[i].ev));
            chk($sformatf("tbl%0d_ovr", i), DW'(overrun), DW'(tbl[i].eo));
            chk($sformatf("tbl%0d_bundle", i), DW'(bundle_valid), DW'(tbl[i].eb));
            chk($sformatf("tbl%0d_d0", i), out_data[0 +: DW], DW'(tbl[i].ed0));
            chk($sformatf("tbl%0d_d1", i), out_data[DW +: DW], DW'(tbl[i].ed1));
        end

        // Bubbles between beats must not move the slot counter.
        do_reset();
        pulse_cnt = 0;
        for (int i = 0; i < 26; i++) begin
            int nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) step(1'b0, 1'b0, 1'b0, rand_row(), '0);
            step(1'b0, 1'b1, 1'b0, DW'(i), '0);
        end
        step(1'b0, 1'b0, 1'b0, '0, '0);
        chk("bub_d0", out_data[0 +: DW], DW'(2));
        chk("bub_d1", out_data[DW +: DW], DW'(14));
        chk("bub_pulses", DW'(pulse_cnt), DW'(1));
        chk("bub_ovr", DW'(overrun), DW'(0));

        // Ack in the same cycle as the capture: capture wins, no overrun.
        do_reset();
        for (int i = 0; i < 28; i++) step(1'b0, 1'b1, 1'b0, DW'(i), '0);
        step(1'b0, 1'b1, 1'b0, DW'(28), 2'b01);
        chk("ackcap_valid0", DW'(out_valid[0]), DW'(1));
        chk("ackcap_d0", out_data[0 +: DW], DW'(28));
        chk("ackcap_ovr0", DW'(overrun[0]), DW'(0));
        step(1'b0, 1'b0, 1'b0, '0, 2'b01);
        chk("ack_clear0", DW'(out_valid[0]), DW'(0));

        // Frame resync with a valid beat at index 7.
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, DW'(i), '0);
        step(1'b0, 1'b1, 1'b1, DW'(7), '0);
        for (int i = 8; i < 22; i++) begin
            step(1'b0, 1'b1, 1'b0, DW'(i), '0);
            if (i == 9) chk("fs_d0", out_data[0 +: DW], DW'(9));
        end
        chk("fs_d1", out_data[DW +: DW], DW'(21));
        chk("fs_bundle", DW'(bundle_valid), DW'(1));
        // Resync without a beat: next valid beat is slot 0.
        step(1'b0, 1'b0, 1'b1, '0, '0);
        for (int j = 0; j < 3; j++) step(1'b0, 1'b1, 1'b0, DW'(100 + j), '0);
        chk("fs_idle_d0", out_data[0 +: DW], DW'(102));

        // Reset mid-period discards the beat and restarts cleanly.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, DW'(i), '0);
        step(1'b1, 1'b1, 1'b0, DW'(10), '0);
        chk("midrst_valid", DW'(out_valid), DW'(0));
        chk("midrst_d0", out_data[0 +: DW], DW'(0));
        chk("midrst_bundle", DW'(bundle_valid), DW'(0));
        pulse_cnt = 0;
        for (int i = 0; i < 26; i++) step(1'b0, 1'b1, 1'b0, DW'(i), '0);
        chk("midrst_re_d0", out_data[0 +: DW], DW'(2));
        chk("midrst_re_d1", out_data[DW +: DW], DW'(14));
        chk("midrst_re_pulses", DW'(pulse_cnt), DW'(1));
        chk("midrst_re_ovr", DW'(overrun), DW'(0));

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            logic r, v, f;
            logic [NCH-1:0] a;
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 9) < 7);
            f = ($urandom_range(0, 39) == 0);
            a = NCH'($urandom);
            step(r, v, f, rand_row(), a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
